// File: rtl/rv_decode_pkg.sv
// Shared types and constants for the RV32I decode stage.
package rv_decode_pkg;

    // Instruction format classes; R must stay at encoding 0 (reset value of fmt).
    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_BAD = 3'd6
    } fmt_t;

    // RV32I base opcodes.
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    // Width-independent part of a decoded instruction; imm and pc are
    // parameter-sized and therefore stored beside it in the stage.
    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [9:0] alu_fn;
        fmt_t       fmt;
        logic       illegal;
    } dec_bundle_t;

    // Map an opcode to its instruction format; unknown opcodes are BAD.
    function automatic fmt_t decode_fmt(input logic [6:0] op);
        fmt_t f;
        case (op)
            OP_REG:                                         f = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE:  f = FMT_I;
            OP_STORE:                                       f = FMT_S;
            OP_BRANCH:                                      f = FMT_B;
            OP_LUI, OP_AUIPC:                               f = FMT_U;
            OP_JAL:                                         f = FMT_J;
            default:                                        f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: assembles the RV32I immediate for the
// given format and sign-extends it from bit 31 of the instruction to XLEN.
// Only instruction bits [31:7] carry immediate data, so only those are taken.
module imm_gen
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  fmt_t            fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32_s;

    // Assemble the 32-bit immediate; R and BAD carry no immediate.
    always_comb begin
        imm32_s = 32'd0;
        case (fmt)
            FMT_I:   imm32_s = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32_s = {{19{instr[31]}}, instr[31], instr[7],
                                instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32_s = {instr[31:12], 12'd0};
            FMT_J:   imm32_s = {{11{instr[31]}}, instr[31], instr[19:12],
                                instr[20], instr[30:21], 1'b0};
            default: imm32_s = 32'd0;
        endcase
    end

    assign imm = XLEN'($signed(imm32_s));

endmodule

// File: rtl/decode_stage.sv
// Registered RISC-V decode stage with a 2-entry skid buffer (main M drives
// the outputs, skid K absorbs the one instruction that arrives while
// downstream stalls). in_ready comes straight from a register.
module decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      opcode,
    output logic [4:0]      rs1_add,
    output logic [4:0]      rs2_add,
    output logic [4:0]      rd_add,
    output logic [9:0]      ins_for_ALU,
    output logic [2:0]      fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

    buf_state_t      state_r, state_nxt_s;
    logic            in_ready_r, out_valid_r;
    dec_bundle_t     dec_s, m_dec_r, k_dec_r;
    logic [XLEN-1:0] imm_s, m_imm_r, k_imm_r;
    logic [PC_W-1:0] m_pc_r, k_pc_r;
    logic            accept_s, drain_s;
    logic            load_m_s, load_k_s, m_from_k_s;

    assign accept_s = in_valid && in_ready_r;
    assign drain_s  = out_valid_r && out_ready;

    // Field split of the incoming instruction word.
    always_comb begin
        dec_s         = '0;
        dec_s.opcode  = in_instr[6:0];
        dec_s.rs1     = in_instr[19:15];
        dec_s.rs2     = in_instr[24:20];
        dec_s.rd      = in_instr[11:7];
        dec_s.alu_fn  = {in_instr[31:25], in_instr[14:12]};
        dec_s.fmt     = decode_fmt(in_instr[6:0]);
        dec_s.illegal = (in_instr[1:0] != 2'b11) || (dec_s.fmt == FMT_BAD);
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr[31:7]),
        .fmt   (dec_s.fmt),
        .imm   (imm_s)
    );

    // Buffer occupancy transitions and which register loads this cycle.
    always_comb begin
        state_nxt_s = state_r;
        load_m_s    = 1'b0;
        load_k_s    = 1'b0;
        m_from_k_s  = 1'b0;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s = ST_ONE;
                        load_m_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && !drain_s) begin
                        state_nxt_s = ST_FULL;
                        load_k_s    = 1'b1;
                    end else if (accept_s && drain_s) begin
                        state_nxt_s = ST_ONE;
                        load_m_s    = 1'b1;
                    end else if (drain_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (drain_s) begin
                        state_nxt_s = ST_ONE;
                        m_from_k_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State, registered handshake outputs and the M/K data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            m_dec_r     <= '0;
            m_imm_r     <= '0;
            m_pc_r      <= '0;
            k_dec_r     <= '0;
            k_imm_r     <= '0;
            k_pc_r      <= '0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s != ST_FULL);
            out_valid_r <= (state_nxt_s != ST_EMPTY);
            if (load_m_s) begin
                m_dec_r <= dec_s;
                m_imm_r <= imm_s;
                m_pc_r  <= in_pc;
            end else if (m_from_k_s) begin
                m_dec_r <= k_dec_r;
                m_imm_r <= k_imm_r;
                m_pc_r  <= k_pc_r;
            end
            if (load_k_s) begin
                k_dec_r <= dec_s;
                k_imm_r <= imm_s;
                k_pc_r  <= in_pc;
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_pc      = m_pc_r;
    assign opcode      = m_dec_r.opcode;
    assign rs1_add     = m_dec_r.rs1;
    assign rs2_add     = m_dec_r.rs2;
    assign rd_add      = m_dec_r.rd;
    assign ins_for_ALU = m_dec_r.alu_fn;
    assign fmt         = m_dec_r.fmt;
    assign imm         = m_imm_r;
    assign illegal     = m_dec_r.illegal;

endmodule
